tetris_pixel_pipe: RTL
======================

Name: tetris_pixel_pipe

Overview:
Registered, parametrised successor to the combinational playfield/text colour mapper. It maps the HDMI scan position (DrawX/DrawY) to 12-bit RGB using a fixed 2-cycle pipeline. Grid cells and font glyphs are fetched from external synchronous memories. The block adds four things the combinational mapper lacks:
- sequential binary-to-BCD score conversion
- optional gridlines
- per-row line-clear flashing
- delay-matched hsync/vsync/vde

It sits between the VGA/HDMI timing generator and the HDMI encoder.

Parameters:
GRID_W, 10, playfield columns
GRID_H, 22, playfield rows including hidden rows
HIDDEN_ROWS, 2, top rows never drawn
CELL_LOG2, 4, cell size is 2^CELL_LOG2 pixels square
FIELD_X0, 240, playfield left pixel
FIELD_Y0, 80, playfield top pixel
LABEL_LEN, 13, label characters
LABEL_X0, 468, label left pixel
LABEL_Y0, 224, label top pixel; digit row is at LABEL_Y0+16
DIGITS, 4, score digits; DIGITS=4 gives max 9999
DIGIT_X0, 538, left pixel of the most-significant digit
FLASH_SHIFT, 3, flash toggles every 2^FLASH_SHIFT frames
CA_W, $clog2(GRID_W*GRID_H), cell address width

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  asynchronous, active-low reset
DrawX  in  10  scan x
DrawY  in  10  scan y
vde_in  in  1  video data enable
hsync_in  in  1  hsync
vsync_in  in  1  vsync; active-high
label  in  7*LABEL_LEN  ASCII codes; char i at bits [7i+6:7i]
score  in  14  binary score
score_load  in  1  one-cycle pulse: convert score
score_busy  out  1  BCD conversion in progress
grid_lines  in  1  gridline mode enable
clear_rows  in  GRID_H  rows pending clear (flash)
cell_addr  out  CA_W  cell read address = row*GRID_W+col
cell_data  in  3  cell code; valid one cycle after cell_addr
font_addr  out  11  {char[6:0], line[3:0]}
font_data  in  8  glyph row; valid one cycle after font_addr; bit 7 = leftmost pixel
Red, Green, Blue  out  4 each  pixel colour
vde_out, hsync_out, vsync_out  out  1 each  inputs delayed by 2 cycles

Behaviour:
Reset values: all outputs 0; displayed BCD digits 0; frame counter 0; score_busy 0.

Pipeline:
- Cycle k: cell_addr and font_addr are combinational from DrawX/DrawY.
- Stage-1 registers capture region flags, cell-local x/y, glyph bit index and row index.
- Edge k+1: memory data is valid.
- Edge k+2: Red/Green/Blue and the delayed syncs/vde are registered.
- Latency is exactly 2 for every pixel. No stalls.

Regions, evaluated in priority order:
1. Field: FIELD_X0 <= x < FIELD_X0+GRID_W<<CELL_LOG2, and FIELD_Y0 <= y < FIELD_Y0+(GRID_H-HIDDEN_ROWS)<<CELL_LOG2.
   - col = (x-FIELD_X0)>>CELL_LOG2; row = ((y-FIELD_Y0)>>CELL_LOG2)+HIDDEN_ROWS.
2. Label: LABEL_Y0 <= y < LABEL_Y0+16 and LABEL_X0 <= x < LABEL_X0+8*LABEL_LEN.
   - char = label[(x-LABEL_X0)>>3]; line = y-LABEL_Y0.
3. Digits: LABEL_Y0+16 <= y < LABEL_Y0+32 and DIGIT_X0 <= x < DIGIT_X0+8*DIGITS.
   - char = 0x30 + BCD digit, most-significant digit leftmost.
4. Otherwise black.

Outside field, label and digit regions, cell_addr and font_addr are don't-care.

Field colour, by cell code:
- 0: FBC
- 1: 777
- 2: 0F0
- 3: F00
- 4: 00F
- 5: F70
- 6: F90
- 7: 707

Field overrides, in priority order:
1. clear_rows[row]=1 and flash=1: FFF. flash = frame_cnt[FLASH_SHIFT].
2. grid_lines=1 and (local x==0 or local y==0): 333.

Text pixels: FFF when the glyph bit [7-(x&7)] is 1, else 000.

Frame counter: increments on the registered rising edge of vsync_in and wraps freely.

Score conversion:
- Iterative double-dabble, one shift per cycle.
- score_load with score > 10^DIGITS-1 saturates to 10^DIGITS-1 (9999 for DIGITS=4).
- score_busy asserts the cycle after score_load and stays high for 14 cycles.
- Displayed digits update atomically on the cycle score_busy falls; there are no partial values.
- score_load while busy restarts conversion with the new value; the last load wins.

Reset mid-conversion: busy clears; digits return to 0.

Test Plan:
1. Reset release, DrawX=0/DrawY=0 streamed with vde=1 -> outputs 000 for 2 cycles, then 000 (black); vde_out follows vde_in with exactly 2-cycle delay.
2. Memory model returns code 3 at address 2*10+0=20; DrawX=240, DrawY=80 -> cell_addr=20; RGB=F00 two cycles later. DrawX=239 -> 000.
3. grid_lines=1, DrawX=256, DrawY=90 -> 333 (local x=0). DrawX=257 -> cell colour.
4. score=1234 with score_load pulse -> score_busy high for 14 cycles. Digit font_addr chars are then 0x31,0x32,0x33,0x34 at x=538/546/554/562. score=12000 -> digits 9999.
5. score_load(500), then score_load(77) 5 cycles later -> final digits 0077; digits never show 0500.
6. clear_rows[5]=1, 8 vsync pulses -> row-5 pixels at y=128..143 FFF while frame_cnt[3]=1, normal colour otherwise. Reset_n pulsed low mid-frame -> frame_cnt 0, all outputs 0 immediately.

Source files
------------

// File: rtl/tetris_pixel_pipe.sv
// Two-stage registered pixel colour pipe for the Tetris playfield, label and score digits.
// Cell and glyph memories are external with one-cycle read latency; syncs are delay-matched.
module tetris_pixel_pipe #(
    parameter int GRID_W      = 10,
    parameter int GRID_H      = 22,
    parameter int HIDDEN_ROWS = 2,
    parameter int CELL_LOG2   = 4,
    parameter int FIELD_X0    = 240,
    parameter int FIELD_Y0    = 80,
    parameter int LABEL_LEN   = 13,
    parameter int LABEL_X0    = 468,
    parameter int LABEL_Y0    = 224,
    parameter int DIGITS      = 4,
    parameter int DIGIT_X0    = 538,
    parameter int FLASH_SHIFT = 3,
    parameter int CA_W        = $clog2(GRID_W*GRID_H)
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic                   vde_in,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [7*LABEL_LEN-1:0] label,
    input  logic [13:0]            score,
    input  logic                   score_load,
    output logic                   score_busy,
    input  logic                   grid_lines,
    input  logic [GRID_H-1:0]      clear_rows,
    output logic [CA_W-1:0]        cell_addr,
    input  logic [2:0]             cell_data,
    output logic [10:0]            font_addr,
    input  logic [7:0]             font_data,
    output logic [3:0]             Red,
    output logic [3:0]             Green,
    output logic [3:0]             Blue,
    output logic                   vde_out,
    output logic                   hsync_out,
    output logic                   vsync_out
);

    localparam int RW        = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int CW        = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int LW        = (LABEL_LEN > 1) ? $clog2(LABEL_LEN) : 1;
    localparam int DW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BCD_W     = 4*DIGITS;
    localparam int FC_W      = FLASH_SHIFT + 1;
    localparam int SCORE_MAX = 10**DIGITS - 1;
    localparam int SHIFTS    = 14;

    localparam logic [11:0] FX_LO  = 12'(FIELD_X0);
    localparam logic [11:0] FX_HI  = 12'(FIELD_X0 + (GRID_W << CELL_LOG2));
    localparam logic [11:0] FY_LO  = 12'(FIELD_Y0);
    localparam logic [11:0] FY_HI  = 12'(FIELD_Y0 + ((GRID_H - HIDDEN_ROWS) << CELL_LOG2));
    localparam logic [11:0] LX_LO  = 12'(LABEL_X0);
    localparam logic [11:0] LX_HI  = 12'(LABEL_X0 + 8*LABEL_LEN);
    localparam logic [11:0] LY_LO  = 12'(LABEL_Y0);
    localparam logic [11:0] LY_MID = 12'(LABEL_Y0 + 16);
    localparam logic [11:0] LY_HI  = 12'(LABEL_Y0 + 32);
    localparam logic [11:0] DX_LO  = 12'(DIGIT_X0);
    localparam logic [11:0] DX_HI  = 12'(DIGIT_X0 + 8*DIGITS);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    // ---------------- region decode and memory addressing (cycle k) ----------------
    logic [11:0]   x_w, y_w, fx_w, fy_w, lx_w, ly_w, dx_w;
    logic          in_field_w, in_label_w, in_digit_w, cell_edge_w;
    logic [CW-1:0] col_w;
    logic [RW-1:0] row_w;
    logic [LW-1:0] lidx_w;
    logic [DW-1:0] didx_w;
    logic [6:0]    char_w;
    logic [6:0]    label_chars_w [LABEL_LEN];
    logic [3:0]    digit_w       [DIGITS];
    logic [BCD_W-1:0] digits_q;

    assign x_w  = {2'b00, DrawX};
    assign y_w  = {2'b00, DrawY};
    assign fx_w = x_w - FX_LO;
    assign fy_w = y_w - FY_LO;
    assign lx_w = x_w - LX_LO;
    assign ly_w = y_w - LY_LO;
    assign dx_w = x_w - DX_LO;

    assign in_field_w = (x_w >= FX_LO) && (x_w < FX_HI) && (y_w >= FY_LO) && (y_w < FY_HI);
    assign in_label_w = !in_field_w && (y_w >= LY_LO) && (y_w < LY_MID)
                        && (x_w >= LX_LO) && (x_w < LX_HI);
    assign in_digit_w = !in_field_w && !in_label_w && (y_w >= LY_MID) && (y_w < LY_HI)
                        && (x_w >= DX_LO) && (x_w < DX_HI);

    assign col_w       = fx_w[CELL_LOG2 +: CW];
    assign row_w       = RW'(fy_w >> CELL_LOG2) + RW'(HIDDEN_ROWS);
    assign cell_edge_w = (fx_w[CELL_LOG2-1:0] == '0) || (fy_w[CELL_LOG2-1:0] == '0);
    assign cell_addr   = CA_W'(row_w) * CA_W'(GRID_W) + CA_W'(col_w);

    assign lidx_w = lx_w[3 +: LW];
    assign didx_w = dx_w[3 +: DW];

    for (genvar gi = 0; gi < LABEL_LEN; gi++) begin : g_label
        assign label_chars_w[gi] = label[7*gi +: 7];
    end

    // Digit 0 on screen is the most-significant BCD nibble.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign digit_w[gi] = digits_q[4*(DIGITS-1-gi) +: 4];
    end

    always_comb begin
        char_w = 7'd0;
        if (in_label_w)
            char_w = label_chars_w[lidx_w];
        else if (in_digit_w)
            char_w = {3'b011, digit_w[didx_w]};
    end

    // The digit row sits exactly 16 lines below the label, so both share the low nibble.
    assign font_addr = {char_w, ly_w[3:0]};

    // ---------------- stage 1 ----------------
    logic          s1_field_q, s1_text_q, s1_edge_q;
    logic [2:0]    s1_bit_q;
    logic [RW-1:0] s1_row_q;
    logic [2:0]    s1_sync_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_field_q <= 1'b0;
            s1_text_q  <= 1'b0;
            s1_edge_q  <= 1'b0;
            s1_bit_q   <= '0;
            s1_row_q   <= '0;
            s1_sync_q  <= '0;
        end else begin
            s1_field_q <= in_field_w;
            s1_text_q  <= in_label_w || in_digit_w;
            s1_edge_q  <= cell_edge_w;
            s1_bit_q   <= DrawX[2:0];
            s1_row_q   <= row_w;
            s1_sync_q  <= {vde_in, hsync_in, vsync_in};
        end
    end

    // ---------------- frame counter for line-clear flashing ----------------
    logic            vs_q;
    logic [FC_W-1:0] frame_q;
    logic            flash_w;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_q    <= 1'b0;
            frame_q <= '0;
        end else begin
            vs_q <= vsync_in;
            if (vsync_in && !vs_q)
                frame_q <= frame_q + FC_W'(1);
        end
    end

    assign flash_w = frame_q[FLASH_SHIFT];

    // ---------------- stage 2: colour ----------------
    function automatic logic [11:0] cell_rgb(input logic [2:0] code);
        case (code)
            3'd0:    return 12'hFBC;
            3'd1:    return 12'h777;
            3'd2:    return 12'h0F0;
            3'd3:    return 12'hF00;
            3'd4:    return 12'h00F;
            3'd5:    return 12'hF70;
            3'd6:    return 12'hF90;
            default: return 12'h707;
        endcase
    endfunction

    logic [11:0] rgb_d, rgb_q;
    logic [2:0]  sync_q;

    always_comb begin
        rgb_d = 12'h000;
        if (s1_field_q) begin
            rgb_d = cell_rgb(cell_data);
            if (grid_lines && s1_edge_q)
                rgb_d = 12'h333;
            if (clear_rows[s1_row_q] && flash_w)
                rgb_d = 12'hFFF;
        end else if (s1_text_q) begin
            rgb_d = font_data[~s1_bit_q] ? 12'hFFF : 12'h000;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_q  <= '0;
            sync_q <= '0;
        end else begin
            rgb_q  <= rgb_d;
            sync_q <= s1_sync_q;
        end
    end

    assign Red   = rgb_q[11:8];
    assign Green = rgb_q[7:4];
    assign Blue  = rgb_q[3:0];
    assign {vde_out, hsync_out, vsync_out} = sync_q;

    // ---------------- score: iterative double-dabble ----------------
    state_t             state_q, state_d;
    logic [13:0]        bin_q;
    logic [BCD_W-1:0]   bcd_q, bcd_adj_w, bcd_next_w;
    logic [3:0]         cnt_q;
    logic [13:0]        score_sat_w;
    logic [BCD_W+13:0]  dd_shift_w;
    logic               last_shift_w;

    assign score_sat_w  = (int'(score) > SCORE_MAX) ? 14'(SCORE_MAX) : score;
    assign last_shift_w = (cnt_q == 4'(SHIFTS-1));

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dabble
        assign bcd_adj_w[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                                 : bcd_q[4*gi +: 4];
    end

    assign dd_shift_w = {bcd_adj_w, bin_q} << 1;
    assign bcd_next_w = dd_shift_w[BCD_W+13:14];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (score_load) state_d = S_SHIFT;
            S_SHIFT: if (score_load)        state_d = S_SHIFT;
                     else if (last_shift_w) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        score_busy = (state_q == S_SHIFT);
    end

    // A new load always restarts from scratch, so the last load wins.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
        end else if (score_load) begin
            bin_q <= score_sat_w;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (state_q == S_SHIFT) begin
            {bcd_q, bin_q} <= dd_shift_w;
            cnt_q          <= cnt_q + 4'd1;
            if (last_shift_w)
                digits_q <= bcd_next_w;
        end
    end

endmodule
